ibex_vector_elem_sequencer: RTL and testbench
=============================================

# ibex_vector_elem_sequencer

Element sequencer for the vector datapath, directly downstream of the vector register file. It accepts one vector operation command and reads the source register groups through two combinational read ports. It then walks elements 0..vl-1 at the configured SEW/LMUL and streams zero-extended element operand pairs to the vector ALU over a valid/ready handshake.

## Interface
Parameters:
- VLEN, 32, bits per vector register; must be a multiple of 32.
- VLMUL_MAX, 4, largest legal register group size.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  sequencer can accept a command.
- cmd_vs1_i, cmd_vs2_i, cmd_vd_i  in  5 each  base register of source groups and destination group.
- cmd_vsew_i  in  3  000=8b, 001=16b, 010=32b; other values are illegal.
- cmd_vlmul_i  in  3  000=1, 001=2, 010=4; other values, or values >VLMUL_MAX, are illegal.
- cmd_vl_i  in  8  element count.
- rf_raddr_a_o, rf_raddr_b_o  out  5 each  register file read addresses.
- rf_rdata_a_i, rf_rdata_b_i  in  VLEN each  read data, combinational from the addresses.
- elem_valid_o  out  1  element pair available.
- elem_ready_i  in  1  ALU accepts the element pair.
- elem_a_o, elem_b_o  out  32 each  element from vs1/vs2 group, zero-extended to 32 bits.
- elem_idx_o  out  8  element index.
- elem_vd_o  out  5  destination register = vd + idx/EPR, where EPR = VLEN/SEW.
- elem_last_o  out  1  element is idx = vl-1.
- err_o  out  1  one-cycle pulse: command rejected.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE and RUN.
- IDLE: cmd_ready_o = 1. A command is accepted when cmd_valid_i && cmd_ready_o. On acceptance the command fields are latched.
- A command is illegal if any of the following holds:
  - vsew is illegal;
  - vlmul is illegal;
  - any of vs1/vs2/vd is not a multiple of LMUL;
  - base + LMUL - 1 > 31 for any of vs1/vs2/vd;
  - vl > VLMAX = EPR*LMUL.
- Illegal command: err_o pulses the next cycle. The state stays IDLE and no element is emitted.
- vl = 0: the command is accepted, the state stays IDLE, nothing is emitted, and there is no error.
- Legal command with vl > 0: the state goes to RUN and the internal index ni = 0.
- RUN behaviour:
  - rf_raddr_a_o = vs1 + ni/EPR and rf_raddr_b_o = vs2 + ni/EPR.
  - The element is bits [(ni mod EPR)*SEW +: SEW] of each read word.
  - The output register loads when !elem_valid_o || elem_ready_i. On load, ni increments.
  - While elem_valid_o && !elem_ready_i, all elem_* outputs are held stable.
  - After element vl-1 has been loaded, no further loads occur.
  - On the handshake of the element with elem_last_o = 1, elem_valid_o drops and the state goes to IDLE.
- In IDLE, rf_raddr_* = 0.
- Index arithmetic: EPR is a power of two, so use shifts and masks. ni is 8 bits, and vl ≤ VLMAX ≤ 64 guarantees no wrap.
- cmd_ready_o is 0 throughout RUN. A command presented then waits.

## Timing
- Reset values (asynchronous): state IDLE, cmd_ready_o = 1, elem_valid_o = 0, elem_* = 0, err_o = 0, busy_o = 0, rf_raddr_* = 0.
- Command accepted at edge N: busy_o = 1 and elem_valid_o = 1 with idx 0 after edge N+1, i.e. first-element latency is 1 cycle.
- Throughput is 1 element/cycle with elem_ready_i held high.
- Last element handshake at edge M: cmd_ready_o = 1 after M. A new command can be accepted at edge M+1, giving one idle cycle between commands.
- err_o is high for exactly the cycle after the rejecting edge.
- Reset asserted mid-RUN: all state is cleared immediately and the in-flight command is discarded.

## Test plan
- VLEN=32, SEW=8, LMUL=1, vl=4, vs1=2, vs2=3, v2=0x44332211, v3=0xDDCCBBAA, ready always high -> 4 consecutive beats:
  - elem_a = 0x11, 0x22, 0x33, 0x44;
  - elem_b = 0xAA..0xDD;
  - elem_last only on idx 3;
  - cmd_ready_o high the cycle after.
- SEW=16, LMUL=4, vl=8, vs1=4, vd=8 -> reads v4..v7 two elements each; elem_vd_o = 8,8,9,9,10,10,11,11.
- Backpressure: deassert elem_ready_i for 3 cycles at idx 2 -> outputs are frozen at idx 2 and no element is skipped or duplicated.
- Illegal commands are rejected: vsew=011, vs1=3 with LMUL=2, and vl=5 at SEW=32/LMUL=4 -> err_o pulses once for each, nothing is emitted, and the block stays IDLE.
- vl=0 -> no elem_valid_o and no err_o; back-to-back second command accepted the next cycle.
- Assert rst_ni low during RUN at idx 1 -> outputs take reset values immediately; after release, a new command runs from idx 0.

Source files
------------

// File: rtl/ibex_vector_elem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ibex_vector_elem_sequencer
// Purpose  : Accepts one vector command, checks its legality, then walks
//            elements 0..vl-1 of the vs1/vs2 register groups at the given
//            SEW/LMUL. Each element pair goes out zero-extended over a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_vector_elem_sequencer #(
  parameter int VLEN      = 32,
  parameter int VLMUL_MAX = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [4:0]      cmd_vs1_i,
  input  logic [4:0]      cmd_vs2_i,
  input  logic [4:0]      cmd_vd_i,
  input  logic [2:0]      cmd_vsew_i,
  input  logic [2:0]      cmd_vlmul_i,
  input  logic [7:0]      cmd_vl_i,
  output logic [4:0]      rf_raddr_a_o,
  output logic [4:0]      rf_raddr_b_o,
  input  logic [VLEN-1:0] rf_rdata_a_i,
  input  logic [VLEN-1:0] rf_rdata_b_i,
  output logic            elem_valid_o,
  input  logic            elem_ready_i,
  output logic [31:0]     elem_a_o,
  output logic [31:0]     elem_b_o,
  output logic [7:0]      elem_idx_o,
  output logic [4:0]      elem_vd_o,
  output logic            elem_last_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int c_LOG2_VLEN = $clog2(VLEN);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      r_state;
  logic [4:0]  r_vs1, r_vs2, r_vd;
  logic [1:0]  r_sew;
  logic [7:0]  r_vl, r_ni;
  logic        r_valid, r_last, r_err;
  logic [31:0] r_elem_a, r_elem_b;
  logic [7:0]  r_idx;
  logic [4:0]  r_elem_vd;

  // A register group is usable when it is LMUL-aligned and stays inside v0..v31
  function automatic logic grp_ok(input logic [4:0] base, input int lmul);
    return ((int'(base) & (lmul - 1)) == 0) && ((int'(base) + lmul - 1) <= 31);
  endfunction

  logic w_sew_ok, w_lmul_ok, w_cmd_illegal;
  int   w_lmul, w_cmd_shift, w_vlmax;

  // Legality of the command currently presented; VLMAX = EPR*LMUL as a shift
  always_comb begin
    w_sew_ok      = (cmd_vsew_i <= 3'd2);
    w_lmul_ok     = (cmd_vlmul_i <= 3'd2) && ((1 << cmd_vlmul_i) <= VLMUL_MAX);
    w_lmul        = w_lmul_ok ? (1 << cmd_vlmul_i) : 1;
    w_cmd_shift   = c_LOG2_VLEN - 3 - (w_sew_ok ? int'(cmd_vsew_i) : 0);
    w_vlmax       = w_lmul << w_cmd_shift;
    w_cmd_illegal = !w_sew_ok || !w_lmul_ok
                 || !grp_ok(cmd_vs1_i, w_lmul)
                 || !grp_ok(cmd_vs2_i, w_lmul)
                 || !grp_ok(cmd_vd_i, w_lmul)
                 || (int'(cmd_vl_i) > w_vlmax);
  end

  int              w_shift, w_sub, w_bit_off;
  logic [4:0]      w_grp_off;
  logic [VLEN-1:0] w_word_a, w_word_b;
  logic [31:0]     w_mask, w_elem_a, w_elem_b;
  logic            w_load;

  // Element addressing: register = base + ni>>log2(EPR), lane = ni & (EPR-1)
  always_comb begin
    w_shift   = c_LOG2_VLEN - 3 - int'(r_sew);
    w_grp_off = 5'(int'(r_ni) >> w_shift);
    w_sub     = int'(r_ni) & ((1 << w_shift) - 1);
    w_bit_off = w_sub << (3 + int'(r_sew));
    w_word_a  = rf_rdata_a_i >> w_bit_off;
    w_word_b  = rf_rdata_b_i >> w_bit_off;
    case (r_sew)
      2'd0:    w_mask = 32'h0000_00FF;
      2'd1:    w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
    w_elem_a  = w_word_a[31:0] & w_mask;
    w_elem_b  = w_word_b[31:0] & w_mask;
    w_load    = (r_state == S_RUN) && (r_ni < r_vl) && (!r_valid || elem_ready_i);
  end

  assign rf_raddr_a_o = (r_state == S_RUN) ? r_vs1 + w_grp_off : 5'd0;
  assign rf_raddr_b_o = (r_state == S_RUN) ? r_vs2 + w_grp_off : 5'd0;

  // Command acceptance, element walk and output register with handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_vs1     <= 5'd0;
      r_vs2     <= 5'd0;
      r_vd      <= 5'd0;
      r_sew     <= 2'd0;
      r_vl      <= 8'd0;
      r_ni      <= 8'd0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      r_elem_a  <= 32'd0;
      r_elem_b  <= 32'd0;
      r_idx     <= 8'd0;
      r_elem_vd <= 5'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_vs1 <= cmd_vs1_i;
            r_vs2 <= cmd_vs2_i;
            r_vd  <= cmd_vd_i;
            r_sew <= cmd_vsew_i[1:0];
            r_vl  <= cmd_vl_i;
            r_ni  <= 8'd0;
            if (w_cmd_illegal) begin
              r_err <= 1'b1;
            end else if (cmd_vl_i != 8'd0) begin
              r_state <= S_RUN;
            end
          end
        end
        default: begin
          if (w_load) begin
            r_valid   <= 1'b1;
            r_elem_a  <= w_elem_a;
            r_elem_b  <= w_elem_b;
            r_idx     <= r_ni;
            r_elem_vd <= r_vd + w_grp_off;
            r_last    <= (r_ni == r_vl - 8'd1);
            r_ni      <= r_ni + 8'd1;
          end else if (r_valid && elem_ready_i) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state == S_RUN);
  assign err_o        = r_err;
  assign elem_valid_o = r_valid;
  assign elem_a_o     = r_elem_a;
  assign elem_b_o     = r_elem_b;
  assign elem_idx_o   = r_idx;
  assign elem_vd_o    = r_elem_vd;
  assign elem_last_o  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_ibex_vector_elem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_vector_elem_sequencer
// Purpose  : Randomized and directed bench for the element sequencer, checked
//            against a queue-based reference model of the element stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_vector_elem_sequencer;

  localparam int VLEN      = 32;
  localparam int VLMUL_MAX = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [4:0]      cmd_vs1_i, cmd_vs2_i, cmd_vd_i;
  logic [2:0]      cmd_vsew_i, cmd_vlmul_i;
  logic [7:0]      cmd_vl_i;
  logic [4:0]      rf_raddr_a_o, rf_raddr_b_o;
  logic [VLEN-1:0] rf_rdata_a_i, rf_rdata_b_i;
  logic            elem_valid_o;
  logic            elem_ready_i;
  logic [31:0]     elem_a_o, elem_b_o;
  logic [7:0]      elem_idx_o;
  logic [4:0]      elem_vd_o;
  logic            elem_last_o;
  logic            err_o;
  logic            busy_o;

  logic [VLEN-1:0] rf [32];

  assign rf_rdata_a_i = rf[rf_raddr_a_o];
  assign rf_rdata_b_i = rf[rf_raddr_b_o];

  always #5 clk_i = ~clk_i;

  ibex_vector_elem_sequencer #(.VLEN(VLEN), .VLMUL_MAX(VLMUL_MAX)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_vs1_i    (cmd_vs1_i),
    .cmd_vs2_i    (cmd_vs2_i),
    .cmd_vd_i     (cmd_vd_i),
    .cmd_vsew_i   (cmd_vsew_i),
    .cmd_vlmul_i  (cmd_vlmul_i),
    .cmd_vl_i     (cmd_vl_i),
    .rf_raddr_a_o (rf_raddr_a_o),
    .rf_raddr_b_o (rf_raddr_b_o),
    .rf_rdata_a_i (rf_rdata_a_i),
    .rf_rdata_b_i (rf_rdata_b_i),
    .elem_valid_o (elem_valid_o),
    .elem_ready_i (elem_ready_i),
    .elem_a_o     (elem_a_o),
    .elem_b_o     (elem_b_o),
    .elem_idx_o   (elem_idx_o),
    .elem_vd_o    (elem_vd_o),
    .elem_last_o  (elem_last_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  idx;
    logic [4:0]  vd;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks  = 0;
  int    n_errors  = 0;
  int    rdy_mode  = 0;
  int    stall_cnt = 0;
  bit    last_seen = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference legality rules, straight arithmetic on the field values
  function automatic bit cmd_legal(input int vs1, input int vs2, input int vd,
                                   input int sew, input int lmul, input int vl);
    int l;
    if (sew > 2 || lmul > 2) return 0;
    l = 1 << lmul;
    if (l > VLMUL_MAX) return 0;
    if ((vs1 % l) != 0 || (vs2 % l) != 0 || (vd % l) != 0) return 0;
    if (vs1 + l - 1 > 31 || vs2 + l - 1 > 31 || vd + l - 1 > 31) return 0;
    if (vl > (VLEN / (8 << sew)) * l) return 0;
    return 1;
  endfunction

  // Expected element stream for a legal command
  function automatic void push_beats(input int vs1, input int vs2, input int vd,
                                     input int sew, input int vl);
    int sewb, epr;
    logic [VLEN-1:0] wa, wb;
    logic [31:0] mask;
    beat_t bt;
    sewb = 8 << sew;
    epr  = VLEN / sewb;
    mask = (sewb == 32) ? 32'hFFFF_FFFF : ((32'd1 << sewb) - 32'd1);
    for (int i = 0; i < vl; i++) begin
      wa      = rf[vs1 + i / epr] >> ((i % epr) * sewb);
      wb      = rf[vs2 + i / epr] >> ((i % epr) * sewb);
      bt.a    = wa[31:0] & mask;
      bt.b    = wb[31:0] & mask;
      bt.idx  = 8'(i);
      bt.vd   = 5'(vd + i / epr);
      bt.last = (i == vl - 1);
      exp_q.push_back(bt);
    end
  endfunction

  // Element monitor: scoreboard on handshakes, stability while stalled
  initial begin : monitor
    beat_t got, want, prev;
    bit    stalled;
    stalled = 0;
    prev    = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stalled = 0;
      end else begin
        got = {elem_a_o, elem_b_o, elem_idx_o, elem_vd_o, elem_last_o};
        if (stalled) check("hold_stable", got, prev);
        if (elem_valid_o && elem_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 96'(exp_q.size()), 96'd1);
          end else begin
            want = exp_q.pop_front();
            check("beat", got, want);
            if (want.last) last_seen = 1;
          end
        end
        stalled = elem_valid_o && !elem_ready_i;
        prev    = got;
      end
    end
  end

  // Ready driver plus the post-last-element cmd_ready check
  initial begin : ready_drv
    elem_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (last_seen) begin
        check("ready_after_last", cmd_ready_o, 1);
        last_seen = 0;
      end
      case (rdy_mode)
        0: elem_ready_i = 1'b1;
        1: elem_ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (elem_valid_o && elem_idx_o == 8'd2 && stall_cnt < 3) begin
            elem_ready_i = 1'b0;
            stall_cnt++;
          end else begin
            elem_ready_i = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic send_cmd(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                          input logic [2:0] sew, input logic [2:0] lmul, input logic [7:0] vl);
    bit ok;
    int guard;
    guard = 0;
    while (!cmd_ready_o && guard < 300) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    check("idle_before_cmd", cmd_ready_o, 1);
    ok = cmd_legal(int'(vs1), int'(vs2), int'(vd), int'(sew), int'(lmul), int'(vl));
    if (ok) push_beats(int'(vs1), int'(vs2), int'(vd), int'(sew), int'(vl));
    cmd_vs1_i   = vs1;
    cmd_vs2_i   = vs2;
    cmd_vd_i    = vd;
    cmd_vsew_i  = sew;
    cmd_vlmul_i = lmul;
    cmd_vl_i    = vl;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    check("err_after_accept", err_o, !ok);
    check("busy_after_accept", busy_o, ok && (vl != 8'd0));
    check("no_valid_at_accept", elem_valid_o, 0);
    if (!ok) begin
      @(posedge clk_i);
      #1;
      check("err_single_pulse", err_o, 0);
      check("idle_after_reject", cmd_ready_o, 1);
    end else if (vl != 8'd0) begin
      @(posedge clk_i);
      #1;
      check("first_valid", elem_valid_o, 1);
      check("first_idx", elem_idx_o, 0);
    end else begin
      check("ready_after_vl0", cmd_ready_o, 1);
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while ((busy_o || exp_q.size() != 0) && g < 300) begin
      @(posedge clk_i);
      #1;
      g++;
    end
    check("done_in_time", 96'(g < 300), 1);
    check("queue_drained", 96'(exp_q.size()), 0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [2:0] s, l;
    logic [4:0] a, b, d;
    int         lm, vmax;
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_vs1_i   = 5'd0;
    cmd_vs2_i   = 5'd0;
    cmd_vd_i    = 5'd0;
    cmd_vsew_i  = 3'd0;
    cmd_vlmul_i = 3'd0;
    cmd_vl_i    = 8'd0;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_outputs", {elem_valid_o, err_o, busy_o, rf_raddr_a_o, rf_raddr_b_o}, 0);
    check("rst_elem", {elem_a_o, elem_b_o, elem_idx_o, elem_vd_o, elem_last_o}, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Byte elements from a single register pair
    rf[2] = 32'h4433_2211;
    rf[3] = 32'hDDCC_BBAA;
    rdy_mode = 0;
    send_cmd(5'd2, 5'd3, 5'd1, 3'd0, 3'd0, 8'd4);
    wait_done();

    // Halfwords across a 4-register group
    send_cmd(5'd4, 5'd12, 5'd8, 3'd1, 3'd2, 8'd8);
    wait_done();

    // Three-cycle stall at idx 2
    rdy_mode  = 2;
    stall_cnt = 0;
    send_cmd(5'd2, 5'd3, 5'd5, 3'd0, 3'd0, 8'd4);
    wait_done();
    check("stall_cycles", stall_cnt, 3);
    rdy_mode = 0;

    // Illegal commands
    send_cmd(5'd0, 5'd0, 5'd0, 3'b011, 3'd0, 8'd1);
    send_cmd(5'd3, 5'd4, 5'd4, 3'd0, 3'd1, 8'd2);
    send_cmd(5'd0, 5'd4, 5'd8, 3'd2, 3'd2, 8'd5);
    wait_done();

    // vl = 0 then an immediate second command
    send_cmd(5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 8'd0);
    send_cmd(5'd2, 5'd3, 5'd6, 3'd0, 3'd0, 8'd2);
    wait_done();

    // Reset while the element at idx 1 is on the outputs
    send_cmd(5'd2, 5'd3, 5'd1, 3'd0, 3'd0, 8'd4);
    @(posedge clk_i);
    #1;
    check("pre_reset_idx", elem_idx_o, 1);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("midrun_rst_outputs", {elem_valid_o, err_o, busy_o, rf_raddr_a_o, rf_raddr_b_o}, 0);
    check("midrun_rst_elem", {elem_a_o, elem_b_o, elem_idx_o, elem_vd_o, elem_last_o}, 0);
    check("midrun_rst_ready", cmd_ready_o, 1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    send_cmd(5'd2, 5'd3, 5'd1, 3'd0, 3'd0, 8'd4);
    wait_done();

    // Randomized commands with random backpressure
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 32; r++) rf[r] = $urandom;
      s  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      l  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      lm = (l <= 3'd2) ? (1 << l) : 1;
      a  = 5'($urandom_range(0, 31)) & ~5'(lm - 1);
      b  = 5'($urandom_range(0, 31)) & ~5'(lm - 1);
      d  = 5'($urandom_range(0, 31)) & ~5'(lm - 1);
      if ($urandom_range(0, 9) == 0) a = 5'($urandom_range(0, 31));
      vmax = (s <= 3'd2) ? (VLEN / (8 << s)) * lm : 4;
      send_cmd(a, b, d, s, l, 8'($urandom_range(0, vmax + 1)));
      wait_done();
    end

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
